washer_plant: RTL and testbench
===============================

WASHER_PLANT -- requirements
Module: washer_plant

Interface
REQ-001 Parameter LEVEL_MAX, default 32, meaning full water level in steps (range 2..63).
REQ-002 Parameter BRAKE_CYCLES, default 4, meaning drum brake dead-time in clocks (range 1..15).
REQ-003 clk  input  1  single clock, rising edge; 1 cycle = 100 ms.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ctrl_fill  input  1  inlet valve command from controller.
REQ-006 ctrl_release  input  1  drain valve command from controller.
REQ-007 ctrl_forward  input  1  drum forward command.
REQ-008 ctrl_reverse  input  1  drum reverse command.
REQ-009 fault_clr  input  1  synchronous clear of sticky fault bits.
REQ-010 level  output  6  current water level, 0..LEVEL_MAX.
REQ-011 level_full  output  1  high iff level == LEVEL_MAX.
REQ-012 level_empty  output  1  high iff level == 0.
REQ-013 motor_fwd  output  1  drum driven forward (state FWD).
REQ-014 motor_rev  output  1  drum driven reverse (state REV).
REQ-015 motor_braking  output  1  drum in brake dead-time (state BRAKE).
REQ-016 fault  output  3  sticky flags: [2] overflow, [1] valve conflict, [0] motor conflict.

Function
REQ-017 Level: fill=1, release=0, level<LEVEL_MAX -> level+1 next cycle.
REQ-018 Level: release=1, fill=0, level>0 -> level-1 next cycle.
REQ-019 Level saturates at 0 and LEVEL_MAX; never wraps.
REQ-020 fill=1 while level==LEVEL_MAX -> level holds, fault[2] set next cycle.
REQ-021 release=1 while level==0 -> level holds, no fault.
REQ-022 fill=1 and release=1 same cycle -> level holds, fault[1] set next cycle.
REQ-023 level_full/level_empty combinational from registered level (no extra latency).
REQ-024 Motor FSM states IDLE, FWD, REV, BRAKE; outputs decoded from state only, exactly one of motor_fwd/motor_rev/motor_braking high or none (IDLE).
REQ-025 IDLE: forward&!reverse -> FWD; reverse&!forward -> REV; both -> stay IDLE, fault[0] set; neither -> IDLE.
REQ-026 FWD: stays while forward&!reverse; otherwise -> BRAKE, brake counter loaded with BRAKE_CYCLES.
REQ-027 REV: stays while reverse&!forward; otherwise -> BRAKE, counter loaded with BRAKE_CYCLES.
REQ-028 FWD/REV with both commands high -> BRAKE and fault[0] set same edge.
REQ-029 BRAKE: counter decrements each cycle; all commands ignored; counter==1 -> IDLE next edge (BRAKE lasts exactly BRAKE_CYCLES cycles).
REQ-030 Direct FWD<->REV transition is forbidden; always via BRAKE.
REQ-031 Drum operation independent of level (empty spin allowed, no fault).
REQ-032 Fault bits sticky until fault_clr; fault_clr clears all bits next edge.
REQ-033 fault_clr coincident with a set condition -> that bit remains set (set wins).

Reset
REQ-034 rst_n low asynchronously forces level=0, motor state IDLE, brake counter=0, fault=3'b000.
REQ-035 Resulting outputs: level_empty=1, level_full=0, motor_fwd=motor_rev=motor_braking=0.
REQ-036 Reset mid-BRAKE or mid-fill aborts immediately; no brake completion after release of reset.
REQ-037 First state change occurs on the first rising clk edge after rst_n deasserts.

Structure
REQ-038 Shared package holds motor state enum (IDLE, FWD, REV, BRAKE) and fault bit index constants (FLT_OVF=2, FLT_VALVE=1, FLT_MOTOR=0).
REQ-039 Motor FSM with brake counter implemented as sub-module washer_motor_fsm; level counter and fault register in top.

Verification
REQ-040 Reset then fill=1 for 40 cycles (LEVEL_MAX=32) -> level reaches 32 at cycle 32, level_full=1, fault=3'b100 from cycle 33.
REQ-041 From level 32, release=1 for 40 cycles -> level 0 after 32 cycles, level_empty=1, fault unchanged, no underflow.
REQ-042 forward=1 for 10 cycles then reverse=1 immediately -> motor_fwd 10 cycles, motor_braking exactly 4 cycles, IDLE 1 cycle, then motor_rev=1.
REQ-043 fill=release=1 one cycle at level 5 -> level stays 5, fault[1]=1; fault_clr pulse -> fault=0 next cycle.
REQ-044 forward=reverse=1 in IDLE -> stays IDLE, fault[0]=1; in FWD -> BRAKE, fault[0]=1.
REQ-045 rst_n low during BRAKE cycle 2 at level 10 -> immediate level=0, IDLE, fault=0; after release forward=1 -> FWD on first edge.

Source files
------------

// File: rtl/washer_plant_pkg.sv
// Shared types and constants for the washer plant model: motor state
// encoding, fault bit positions and the water-level step function.
package washer_plant_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    REV   = 2'd2,
    BRAKE = 2'd3
  } motor_state_e;

  localparam int FAULT_W   = 3;
  localparam int FLT_OVF   = 2;
  localparam int FLT_VALVE = 1;
  localparam int FLT_MOTOR = 0;

  // Next water level for one cycle of valve commands. Saturates at 0 and at
  // lmax. Both valves open, or neither open, leaves the level unchanged.
  function automatic logic [5:0] level_next(input logic [5:0] lvl,
                                            input logic       fill,
                                            input logic       rel,
                                            input logic [5:0] lmax);
    logic [5:0] nxt;
    nxt = lvl;
    case ({fill, rel})
      2'b10: begin
        if (lvl < lmax) nxt = lvl + 6'd1;
        else            nxt = lvl;
      end
      2'b01: begin
        if (lvl != 6'd0) nxt = lvl - 6'd1;
        else             nxt = lvl;
      end
      default: nxt = lvl;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/washer_motor_fsm.sv
// Drum motor controller: IDLE/FWD/REV/BRAKE with a brake dead-time counter.
// A reversal always passes through BRAKE; conflicting commands are flagged
// through o_conflict for the fault register in the top level.
module washer_motor_fsm
  import washer_plant_pkg::*;
#(
  parameter int BRAKE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_forward,
  input  logic i_reverse,
  output logic o_motor_fwd,
  output logic o_motor_rev,
  output logic o_motor_braking,
  output logic o_conflict
);

  localparam logic [3:0] BRAKE_LOAD = 4'(BRAKE_CYCLES);

  motor_state_e r_state;
  motor_state_e w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic         w_conflict;

  // State and brake counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, brake counter and conflict detection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_conflict  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = 4'd0;
        if (i_forward && i_reverse) begin
          w_state_nxt = IDLE;
          w_conflict  = 1'b1;
        end else if (i_forward) begin
          w_state_nxt = FWD;
        end else if (i_reverse) begin
          w_state_nxt = REV;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FWD: begin
        if (i_forward && !i_reverse) begin
          w_state_nxt = FWD;
        end else begin
          w_state_nxt = BRAKE;
          w_cnt_nxt   = BRAKE_LOAD;
          w_conflict  = i_forward && i_reverse;
        end
      end
      REV: begin
        if (i_reverse && !i_forward) begin
          w_state_nxt = REV;
        end else begin
          w_state_nxt = BRAKE;
          w_cnt_nxt   = BRAKE_LOAD;
          w_conflict  = i_forward && i_reverse;
        end
      end
      BRAKE: begin
        // Commands are ignored here; the counter alone sets the dwell time.
        if (r_cnt <= 4'd1) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = BRAKE;
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign o_motor_fwd     = (r_state == FWD);
  assign o_motor_rev     = (r_state == REV);
  assign o_motor_braking = (r_state == BRAKE);
  assign o_conflict      = w_conflict;

endmodule

// File: rtl/washer_plant.sv
// Washer plant model: water level counter driven by inlet/drain valves,
// sticky fault register, and the drum motor controller.
module washer_plant
  import washer_plant_pkg::*;
#(
  parameter int LEVEL_MAX    = 32,
  parameter int BRAKE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctrl_fill,
  input  logic               ctrl_release,
  input  logic               ctrl_forward,
  input  logic               ctrl_reverse,
  input  logic               fault_clr,
  output logic [5:0]         level,
  output logic               level_full,
  output logic               level_empty,
  output logic               motor_fwd,
  output logic               motor_rev,
  output logic               motor_braking,
  output logic [FAULT_W-1:0] fault
);

  localparam logic [5:0] LVL_MAX = 6'(LEVEL_MAX);

  logic [5:0]         r_level;
  logic [5:0]         w_level_nxt;
  logic [FAULT_W-1:0] r_fault;
  logic [FAULT_W-1:0] w_fault_set;
  logic [FAULT_W-1:0] w_fault_nxt;
  logic               w_motor_conflict;

  washer_motor_fsm #(
    .BRAKE_CYCLES(BRAKE_CYCLES)
  ) u_motor (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_forward      (ctrl_forward),
    .i_reverse      (ctrl_reverse),
    .o_motor_fwd    (motor_fwd),
    .o_motor_rev    (motor_rev),
    .o_motor_braking(motor_braking),
    .o_conflict     (w_motor_conflict)
  );

  // Fault set conditions and next fault value; a set beats a coincident clear.
  always_comb begin
    w_fault_set            = 3'b000;
    w_fault_set[FLT_OVF]   = ctrl_fill && !ctrl_release && (r_level == LVL_MAX);
    w_fault_set[FLT_VALVE] = ctrl_fill && ctrl_release;
    w_fault_set[FLT_MOTOR] = w_motor_conflict;
    if (fault_clr) begin
      w_fault_nxt = w_fault_set;
    end else begin
      w_fault_nxt = r_fault | w_fault_set;
    end
  end

  assign w_level_nxt = level_next(r_level, ctrl_fill, ctrl_release, LVL_MAX);

  // Water level and fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 6'd0;
      r_fault <= 3'b000;
    end else begin
      r_level <= w_level_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign level       = r_level;
  assign level_full  = (r_level == LVL_MAX);
  assign level_empty = (r_level == 6'd0);
  assign fault       = r_fault;

endmodule

// File: tb/tb_washer_plant.sv
// Directed self-checking bench for washer_plant (LEVEL_MAX=32, BRAKE_CYCLES=4).
module tb_washer_plant;

  logic       clk;
  logic       rst_n;
  logic       ctrl_fill;
  logic       ctrl_release;
  logic       ctrl_forward;
  logic       ctrl_reverse;
  logic       fault_clr;
  logic [5:0] level;
  logic       level_full;
  logic       level_empty;
  logic       motor_fwd;
  logic       motor_rev;
  logic       motor_braking;
  logic [2:0] fault;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cnt;

  washer_plant #(
    .LEVEL_MAX   (32),
    .BRAKE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_fill    (ctrl_fill),
    .ctrl_release (ctrl_release),
    .ctrl_forward (ctrl_forward),
    .ctrl_reverse (ctrl_reverse),
    .fault_clr    (fault_clr),
    .level        (level),
    .level_full   (level_full),
    .level_empty  (level_empty),
    .motor_fwd    (motor_fwd),
    .motor_rev    (motor_rev),
    .motor_braking(motor_braking),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mot();
    return {5'd0, motor_fwd, motor_rev, motor_braking};
  endfunction

  initial begin
    rst_n = 1'b0; ctrl_fill = 1'b0; ctrl_release = 1'b0;
    ctrl_forward = 1'b0; ctrl_reverse = 1'b0; fault_clr = 1'b0;
    #12;
    chk("rst_level", {2'd0, level}, 8'd0);
    chk("rst_empty", {7'd0, level_empty}, 8'd1);
    chk("rst_full", {7'd0, level_full}, 8'd0);
    chk("rst_motor", mot(), 8'd0);
    chk("rst_fault", {5'd0, fault}, 8'd0);
    step();
    rst_n = 1'b1;

    // Fill past full: saturate at 32, overflow fault one cycle later.
    ctrl_fill = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1)  chk("fill_c1", {2'd0, level}, 8'd1);
      if (c == 31) chk("fill_c31_full", {7'd0, level_full}, 8'd0);
      if (c == 32) begin
        chk("fill_c32_level", {2'd0, level}, 8'd32);
        chk("fill_c32_full", {7'd0, level_full}, 8'd1);
        chk("fill_c32_fault", {5'd0, fault}, 8'd0);
      end
      if (c == 33) chk("fill_c33_fault", {5'd0, fault}, 8'h4);
    end
    chk("fill_end_level", {2'd0, level}, 8'd32);

    // Drain past empty: no underflow, fault unchanged.
    ctrl_fill = 1'b0; ctrl_release = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1)  chk("drain_c1", {2'd0, level}, 8'd31);
      if (c == 32) begin
        chk("drain_c32_level", {2'd0, level}, 8'd0);
        chk("drain_c32_empty", {7'd0, level_empty}, 8'd1);
      end
    end
    chk("drain_end_level", {2'd0, level}, 8'd0);
    chk("drain_end_fault", {5'd0, fault}, 8'h4);
    ctrl_release = 1'b0; fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_ovf", {5'd0, fault}, 8'd0);

    // Valve conflict at level 5.
    ctrl_fill = 1'b1;
    repeat (5) step();
    ctrl_fill = 1'b0;
    chk("lvl5", {2'd0, level}, 8'd5);
    ctrl_fill = 1'b1; ctrl_release = 1'b1;
    step();
    ctrl_fill = 1'b0; ctrl_release = 1'b0;
    chk("valve_level", {2'd0, level}, 8'd5);
    chk("valve_fault", {5'd0, fault}, 8'h2);
    step();
    chk("valve_sticky", {5'd0, fault}, 8'h2);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("valve_clr", {5'd0, fault}, 8'd0);
    // Set wins over coincident clear.
    ctrl_fill = 1'b1; ctrl_release = 1'b1; fault_clr = 1'b1;
    step();
    ctrl_fill = 1'b0; ctrl_release = 1'b0;
    chk("set_wins", {5'd0, fault}, 8'h2);
    step();
    fault_clr = 1'b0;
    chk("set_wins_clr", {5'd0, fault}, 8'd0);

    // Forward 10 cycles, then reverse: BRAKE 4, IDLE 1, then REV.
    ctrl_forward = 1'b1;
    n_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (motor_fwd) n_cnt++;
    end
    chk("fwd_cycles", 8'(n_cnt), 8'd10);
    ctrl_forward = 1'b0; ctrl_reverse = 1'b1;
    n_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (mot() == 8'd1) n_cnt++;
    end
    chk("brake_cycles", 8'(n_cnt), 8'd4);
    step();
    chk("rev_idle_gap", mot(), 8'd0);
    step();
    chk("rev_on", mot(), 8'd2);
    ctrl_reverse = 1'b0;
    step();
    chk("rev_to_brake", mot(), 8'd1);
    repeat (3) step();
    step();
    chk("rev_brake_done", mot(), 8'd0);
    chk("spin_no_fault", {5'd0, fault}, 8'd0);
    chk("spin_level", {2'd0, level}, 8'd5);

    // Motor conflict in IDLE and in FWD.
    ctrl_forward = 1'b1; ctrl_reverse = 1'b1;
    step();
    ctrl_forward = 1'b0; ctrl_reverse = 1'b0;
    chk("idle_both_motor", mot(), 8'd0);
    chk("idle_both_fault", {5'd0, fault}, 8'h1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("motor_clr", {5'd0, fault}, 8'd0);
    ctrl_forward = 1'b1;
    step();
    chk("fwd_on", mot(), 8'd4);
    ctrl_reverse = 1'b1;
    step();
    ctrl_forward = 1'b0; ctrl_reverse = 1'b0;
    chk("fwd_both_brake", mot(), 8'd1);
    chk("fwd_both_fault", {5'd0, fault}, 8'h1);
    repeat (3) step();
    chk("fwd_both_brake4", mot(), 8'd1);
    step();
    chk("fwd_both_idle", mot(), 8'd0);

    // Reset during BRAKE cycle 2 at level 10.
    ctrl_fill = 1'b1;
    repeat (5) step();
    ctrl_fill = 1'b0;
    chk("lvl10", {2'd0, level}, 8'd10);
    ctrl_forward = 1'b1;
    step();
    ctrl_forward = 1'b0;
    step();
    step();
    chk("brake2", mot(), 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_level", {2'd0, level}, 8'd0);
    chk("arst_empty", {7'd0, level_empty}, 8'd1);
    chk("arst_motor", mot(), 8'd0);
    chk("arst_fault", {5'd0, fault}, 8'd0);
    step();
    chk("arst_hold_motor", mot(), 8'd0);
    rst_n = 1'b1;
    ctrl_forward = 1'b1;
    step();
    ctrl_forward = 1'b0;
    chk("post_rst_fwd", mot(), 8'd4);
    chk("post_rst_level", {2'd0, level}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
